// File: rtl/sat_clamp_pipe.sv
// sat_clamp_pipe: two-stage valid/ready saturating narrower, IN_W signed -> OUT_W.
// Each lane clamps independently in signed or unsigned mode and reports overflow/underflow.
// Optional macro SAT_STATS_EN adds a saturating count of clamped lanes (sat_count).
module sat_clamp_pipe #(
  parameter int CHANNELS = 1,
  parameter int IN_W     = 11,
  parameter int OUT_W    = 9,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode_unsigned,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*IN_W-1:0]  in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*OUT_W-1:0] out_data,
  output logic [CHANNELS-1:0]       out_ovf,
  output logic [CHANNELS-1:0]       out_unf,
  input  logic                      stats_clr,
  output logic [CNT_W-1:0]          sat_count
);

  // Clamp thresholds expressed in the input width.
  localparam logic signed [IN_W-1:0] SMAX = IN_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] SMIN = IN_W'(-(1 << (OUT_W - 1)));
  localparam logic signed [IN_W-1:0] UMAX = IN_W'((1 << OUT_W) - 1);

  // Saturated output codes.
  localparam logic [OUT_W-1:0] OSMAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OSMIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] OUMAX = {OUT_W{1'b1}};
  localparam logic [OUT_W-1:0] OUMIN = '0;

  function automatic logic lane_ovf(input logic signed [IN_W-1:0] x, input logic uns);
    if (uns) return (x > UMAX);
    else     return (x > SMAX);
  endfunction

  function automatic logic lane_unf(input logic signed [IN_W-1:0] x, input logic uns);
    if (uns) return x[IN_W-1];
    else     return (x < SMIN);
  endfunction

  function automatic logic [OUT_W-1:0] clamp_lane(input logic signed [IN_W-1:0] x,
                                                  input logic uns,
                                                  input logic ovf,
                                                  input logic unf);
    if (ovf)      return uns ? OUMAX : OSMAX;
    else if (unf) return uns ? OUMIN : OSMIN;
    else if (uns) return x[OUT_W-1:0];
    else          return {x[IN_W-1], x[OUT_W-2:0]};
  endfunction

  logic                      en;
  logic [CHANNELS-1:0]       ovf_p0, unf_p0;

  logic                      vld_p1;
  logic                      mode_p1;
  logic [CHANNELS*IN_W-1:0]  data_p1;
  logic [CHANNELS-1:0]       ovf_p1, unf_p1;

  logic                      vld_p2;
  logic [CHANNELS*OUT_W-1:0] data_p2;
  logic [CHANNELS-1:0]       ovf_p2, unf_p2;

  // The whole pipe advances together; a stalled output freezes both stages.
  assign en       = !vld_p2 || out_ready;
  assign in_ready = en;

  // ---- stage 0 -> 1: per-lane threshold compares on the incoming beat
  // Compare every lane against the bounds selected by this beat's mode.
  always_comb begin
    ovf_p0 = '0;
    unf_p0 = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      ovf_p0[i] = lane_ovf($signed(in_data[i*IN_W +: IN_W]), mode_unsigned);
      unf_p0[i] = lane_unf($signed(in_data[i*IN_W +: IN_W]), mode_unsigned);
    end
  end

  // S1 valid: the only stage-1 state that needs a defined reset value.
  always_ff @(posedge clk) begin
    if (rst)     vld_p1 <= 1'b0;
    else if (en) vld_p1 <= in_valid;
  end

  // S1 payload: raw data, mode and compare results, held while stalled.
  always_ff @(posedge clk) begin
    if (en) begin
      data_p1 <= in_data;
      mode_p1 <= mode_unsigned;
      ovf_p1  <= ovf_p0;
      unf_p1  <= unf_p0;
    end
  end

  // ---- stage 1 -> 2: select clamped value per lane and register outputs
  // S2 outputs are cleared on reset so the port reads zero until the first beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      ovf_p2  <= '0;
      unf_p2  <= '0;
    end else if (en) begin
      vld_p2 <= vld_p1;
      ovf_p2 <= ovf_p1;
      unf_p2 <= unf_p1;
      for (int i = 0; i < CHANNELS; i++) begin
        data_p2[i*OUT_W +: OUT_W] <= clamp_lane($signed(data_p1[i*IN_W +: IN_W]),
                                                mode_p1, ovf_p1[i], unf_p1[i]);
      end
    end
  end

  assign out_valid = vld_p2;
  assign out_data  = data_p2;
  assign out_ovf   = ovf_p2;
  assign out_unf   = unf_p2;

`ifdef SAT_STATS_EN
  localparam int PW = $clog2(CHANNELS + 1);
  localparam int SW = CNT_W + PW;

  function automatic logic [PW-1:0] popcount(input logic [CHANNELS-1:0] v);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < CHANNELS; i++) c = c + PW'(v[i]);
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PW-1:0] b);
    logic [SW-1:0] s;
    s = {{PW{1'b0}}, a} + {{CNT_W{1'b0}}, b};
    if (|s[SW-1:CNT_W]) return {CNT_W{1'b1}};
    else                return s[CNT_W-1:0];
  endfunction

  logic [CNT_W-1:0] cnt_q;

  // Count clamped lanes on each output handshake; clear takes priority and the count never wraps.
  always_ff @(posedge clk) begin
    if (rst || stats_clr)         cnt_q <= '0;
    else if (vld_p2 && out_ready) cnt_q <= sat_add(cnt_q, popcount(ovf_p2 | unf_p2));
  end

  assign sat_count = cnt_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign sat_count        = '0;
`endif

endmodule

// File: tb/tb_sat_clamp_pipe.sv
// Directed bench for sat_clamp_pipe with four 11->9 lanes: clamping, latency, stream order,
// backpressure, mid-flight reset and the saturation counter (SAT_STATS_EN builds use CNT_W=2).
module tb_sat_clamp_pipe;
  localparam int CH = 4;
  localparam int IW = 11;
  localparam int OW = 9;
`ifdef SAT_STATS_EN
  localparam int CW      = 2;
  localparam int EXP_SAT = 3;
`else
  localparam int CW      = 16;
  localparam int EXP_SAT = 0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             mode_unsigned;
  logic             in_valid;
  logic             in_ready;
  logic [CH*IW-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [CH*OW-1:0] out_data;
  logic [CH-1:0]    out_ovf;
  logic [CH-1:0]    out_unf;
  logic             stats_clr;
  logic [CW-1:0]    sat_count;

  int checks = 0;
  int errors = 0;

  sat_clamp_pipe #(.CHANNELS(CH), .IN_W(IW), .OUT_W(OW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .mode_unsigned(mode_unsigned),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .out_unf(out_unf),
    .stats_clr(stats_clr), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [CH*IW-1:0] pin(input logic [IW-1:0] l3, input logic [IW-1:0] l2,
                                           input logic [IW-1:0] l1, input logic [IW-1:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [CH*OW-1:0] pout(input logic [OW-1:0] l3, input logic [OW-1:0] l2,
                                            input logic [OW-1:0] l1, input logic [OW-1:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  // One isolated beat into an empty pipe: absent after one cycle, present after two.
  task automatic one_beat(input string tag, input logic [CH*IW-1:0] din, input logic mode,
                          input logic [CH*OW-1:0] ed, input logic [CH-1:0] eo,
                          input logic [CH-1:0] eu);
    @(negedge clk);
    in_data = din; mode_unsigned = mode; in_valid = 1'b1;
    #1 chk({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_lat1_valid"}, out_valid, 0);
    @(negedge clk);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"}, out_data, ed);
    chk({tag, "_ovf"}, out_ovf, eo);
    chk({tag, "_unf"}, out_unf, eu);
  endtask

  logic [CH*OW-1:0] tog_d [2];
  logic [CH-1:0]    tog_o [2];
  logic [CH-1:0]    tog_u [2];

  initial begin
    int sent, recv, stall_left;
    bit started;
    logic [CH*OW-1:0] held;

    // Reset with out_ready low: in_ready must still be high since nothing is valid.
    rst = 1'b1; in_valid = 1'b0; in_data = '0; mode_unsigned = 1'b0;
    out_ready = 1'b0; stats_clr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_out_unf", out_unf, 0);
    chk("rst_sat_count", sat_count, 0);
    rst = 1'b0; out_ready = 1'b1;

    // Signed: -1 passes, 256 overflows, -512 underflows, 255 passes.
    one_beat("signed", pin(11'h0FF, 11'h600, 11'h100, 11'h7FF), 1'b0,
             pout(9'h0FF, 9'h100, 9'h0FF, 9'h1FF), 4'b0010, 4'b0100);
    // Unsigned: -1 underflows, 512 overflows, 0xAB and 511 pass.
    one_beat("unsigned", pin(11'h1FF, 11'h0AB, 11'h200, 11'h7FF), 1'b1,
             pout(9'h1FF, 9'h0AB, 9'h1FF, 9'h000), 4'b0010, 4'b0001);
    // Four independent lanes: 1023 ovf, 1 pass, -1024 unf, 255 pass.
    one_beat("lanes4", pin(11'h0FF, 11'h400, 11'h001, 11'h3FF), 1'b0,
             pout(9'h0FF, 9'h100, 9'h001, 9'h0FF), 4'b0001, 4'b0100);
    // Signed edges: 255 and -256 pass, -257 underflows, 0 passes.
    one_beat("sbound", pin(11'h000, 11'h6FF, 11'h700, 11'h0FF), 1'b0,
             pout(9'h000, 9'h100, 9'h100, 9'h0FF), 4'b0000, 4'b0100);

    // Back-to-back beats with mode toggled every beat; same lane values each time.
    tog_d[0] = pout(9'h0AB, 9'h0FF, 9'h0FF, 9'h1FF); tog_o[0] = 4'b0110; tog_u[0] = 4'b0000;
    tog_d[1] = pout(9'h0AB, 9'h100, 9'h1FF, 9'h000); tog_o[1] = 4'b0010; tog_u[1] = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i < 4) begin
        in_valid = 1'b1; in_data = pin(11'h0AB, 11'h100, 11'h200, 11'h7FF);
        mode_unsigned = i[0];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (i >= 2) begin
        chk($sformatf("toggle%0d_valid", i - 2), out_valid, 1);
        chk($sformatf("toggle%0d_data", i - 2), out_data, tog_d[(i - 2) % 2]);
        chk($sformatf("toggle%0d_ovf", i - 2), out_ovf, tog_o[(i - 2) % 2]);
        chk($sformatf("toggle%0d_unf", i - 2), out_unf, tog_u[(i - 2) % 2]);
      end
    end

    // Backpressure: five beats, out_ready held low for four cycles after the first output.
    sent = 0; recv = 0; stall_left = 0; started = 0; held = '0;
    mode_unsigned = 1'b0;
    for (int cyc = 0; cyc < 40 && recv < 5; cyc++) begin
      @(negedge clk);
      if (out_valid && !started) begin
        started = 1; stall_left = 4; held = out_data;
      end
      out_ready = (stall_left == 0);
      in_valid  = (sent < 5);
      in_data   = {33'd0, 11'(16 + sent)};
      #1;
      if (stall_left > 0) begin
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_data_stable", out_data, held);
        chk("bp_valid_held", out_valid, 1);
        stall_left--;
      end
      if (out_valid && out_ready) begin
        chk($sformatf("bp_beat%0d", recv), out_data, {27'd0, 9'(16 + recv)});
        recv++;
      end
      if (in_valid && in_ready) sent++;
    end
    chk("bp_received", recv, 5);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1 chk("bp_no_duplicate", out_valid, 0);

    // Mid-flight reset: beat 0 at the output, beat 1 in stage 1.
    @(negedge clk);
    in_valid = 1'b1; in_data = pin(11'h000, 11'h000, 11'h000, 11'h055);
    @(negedge clk);
    in_data = pin(11'h000, 11'h000, 11'h000, 11'h056);
    @(negedge clk);
    chk("pre_rst_valid", out_valid, 1);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_ovf", out_ovf, 0);
    chk("midrst_out_unf", out_unf, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_sat_count", sat_count, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("midrst_no_stale%0d", i), out_valid, 0);
    end

    // Counter: 4 + 1 clamped lanes; saturates when enabled, stays 0 otherwise.
    one_beat("st4", pin(11'h3FF, 11'h3FF, 11'h3FF, 11'h3FF), 1'b0,
             pout(9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF), 4'b1111, 4'b0000);
    one_beat("st1", pin(11'h000, 11'h000, 11'h000, 11'h3FF), 1'b0,
             pout(9'h000, 9'h000, 9'h000, 9'h0FF), 4'b0001, 4'b0000);
    @(negedge clk);
    chk("sat_count_sticky", sat_count, EXP_SAT);

    // Clear in the same cycle as a clamped handshake: clear wins.
    one_beat("stclr", pin(11'h000, 11'h000, 11'h000, 11'h3FF), 1'b0,
             pout(9'h000, 9'h000, 9'h000, 9'h0FF), 4'b0001, 4'b0000);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    chk("sat_count_clear_wins", sat_count, 0);
    @(negedge clk);
    chk("sat_count_after_clear", sat_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
